uart_tx_scheduler: RTL
======================

# uart_tx_scheduler

Shares the single UARTInterface transmitter between several report sources, such as the angle reporter, per-mic level reporters and noise-event flags. Each source raises a request with a fixed-width payload. The scheduler grants sources round-robin, latches the winning payload and serialises it as a framed packet, one byte at a time, through the UART `data_rdy`/`tx_busy` handshake. It sits between the detection/angle logic and `UARTInterface` in the top level.

## Interface
- `NUM_REQ`, default 3: number of requesters, 2..8.
- `PAYLOAD_BYTES`, default 2: payload bytes per packet, 1..4.
- `clock`  in  1: system clock, 100 MHz.
- `reset_n`  in  1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `req`  in  NUM_REQ: per-source request, held high until that source's `ack`.
- `payload`  in  NUM_REQ x (8*PAYLOAD_BYTES): per-source payload, sent MSB byte first.
- `ack`  out  NUM_REQ: one-cycle pulse; that source's payload has been latched.
- `uart_data`  out  8: byte to the UART.
- `uart_data_rdy`  out  1: one-cycle start pulse to the UART.
- `uart_tx_busy`  in  1: UART busy flag.
- `busy`  out  1: high while a packet is in flight (any state other than IDLE).

## Operation
- Packet format: SYNC (8'hA5), ID, P[n-1]..P[0], CHK.
  - ID = grant index, zero-extended to 8 bits.
  - CHK = XOR of ID and all payload bytes. SYNC is excluded.
  - Packet length = PAYLOAD_BYTES + 3 bytes.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO.
  - IDLE: if any `req` is high, select the winner round-robin, latch its payload into a shift register, pulse `ack[winner]`, clear the byte index, go to ISSUE.
  - ISSUE: only when `uart_tx_busy` is low, drive `uart_data` with byte[index] and pulse `uart_data_rdy`, then go to WAIT_HI. While `uart_tx_busy` is high, stay in ISSUE.
  - WAIT_HI: wait for `uart_tx_busy` to go high, then go to WAIT_LO.
  - WAIT_LO: wait for `uart_tx_busy` to go low. Then, if index equals the last byte, go to IDLE; otherwise increment the index and go to ISSUE.
- Round-robin:
  - A pointer holds the last granted index.
  - The search starts at pointer+1 mod NUM_REQ.
  - The pointer updates only on a grant.
- CHK accumulator: cleared on grant, XORed with each ID and payload byte as it is issued. The final byte sent is the accumulator value.
- Requests arriving during a packet wait. No request is dropped; a `req` held high is eventually granted.
- Changes to `payload` after `ack` have no effect on the packet in flight.
- `uart_data` holds its last value between pulses.

## Timing
- Reset values:
  - `ack` = 0, `uart_data_rdy` = 0, `uart_data` = 8'h00, `busy` = 0.
  - State = IDLE, pointer = NUM_REQ-1, so `req[0]` wins first; index = 0; CHK = 0.
- Grant to `ack`: `req` sampled high in IDLE at edge k gives `ack` high during cycle k+1. `busy` also rises at k+1.
- First `uart_data_rdy` appears at cycle k+2 at the earliest, when `uart_tx_busy` is low.
- Between consecutive `uart_data_rdy` pulses: `tx_busy` high time plus at least 3 cycles.
- After the CHK byte completes (`tx_busy` falls), the FSM returns to IDLE. A pending request is granted on the next edge, with no idle gap beyond that one cycle.
- Simultaneous requests: exactly one grant per packet, chosen by the round-robin order.
- `uart_data_rdy` is never asserted while `uart_tx_busy` is high.
- `reset_n` low mid-packet: immediately return to the reset values. The partial packet is abandoned. The UART may finish its current byte, and ISSUE waits for `tx_busy` low before sending again.

## Structure
- Package `utils` holds:
  - the `uart_sched_state_t` enum (IDLE, ISSUE, WAIT_HI, WAIT_LO);
  - `UART_SYNC_BYTE` = 8'hA5.
- Sub-module `rr_arbiter`, parameterised by N:
  - inputs: `req`, `last_grant`, `grant_en`;
  - outputs: one-hot `grant`, `grant_idx`, `any_req`;
  - registered pointer inside, with the same clock and reset.
- The top-level then instantiates one `uart_tx_scheduler` feeding `UARTInterface`.

## Test plan
All scenarios use NUM_REQ=3, PAYLOAD_BYTES=2 and a UART model that holds `tx_busy` high 20 cycles, starting the cycle after `data_rdy`.
- **Single source:** `req[1]` with `payload[1]`=16'h12B4 -> one `ack[1]` pulse; bytes A5, 01, 12, B4, A7; `busy` falls after the last byte.
- **Simultaneous from reset:** `req[0]` and `req[2]` asserted together -> ID 00 packet fully sent, then ID 02. Every `uart_data_rdy` pulse occurs with `tx_busy` low.
- **Round-robin rotation:** all three `req` held continuously -> ID order 00, 01, 02, 00. `payload[0]`=16'h00B4 gives CHK B4.
- **Payload stability:** change `payload[1]` to 16'hFFFF the cycle after `ack[1]` -> the bytes sent are still 12, B4, A7.
- **Stall:** hold `tx_busy` high 200 cycles mid-packet -> no `uart_data_rdy` during the stall; the remaining bytes follow once `tx_busy` drops.
- **Reset mid-packet:** `reset_n` low after the ID byte -> all outputs at reset values within the same cycle. After release with `req[2]` high, a complete packet A5, 02, ... is sent and `req[0]` priority is restored.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART transmit scheduler.
//   uart_sched_state_t : scheduler FSM state encoding
//   UART_SYNC_BYTE     : first byte of every packet
package utils;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } uart_sched_state_t;

  localparam logic [7:0] UART_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Request/payload/ack bundle from report sources plus the UART byte handshake.
//   master : scheduler side (drives ack, uart_data, uart_data_rdy, busy)
//   slave  : sources + UART side (drives req, payload, uart_tx_busy)
interface uart_tx_scheduler_if #(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned PAYLOAD_BYTES = 2
);

  logic [NUM_REQ-1:0]                          req;
  logic [NUM_REQ-1:0][8*PAYLOAD_BYTES-1:0]     payload;
  logic [NUM_REQ-1:0]                          ack;
  logic [7:0]                                  uart_data;
  logic                                        uart_data_rdy;
  logic                                        uart_tx_busy;
  logic                                        busy;

  modport master (
    input  req, payload, uart_tx_busy,
    output ack, uart_data, uart_data_rdy, busy
  );

  modport slave (
    output req, payload, uart_tx_busy,
    input  ack, uart_data, uart_data_rdy, busy
  );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter with a registered last-grant pointer.
//   req        : per-source requests
//   last_grant : index loaded into the pointer when grant_en is high
//   grant_en   : a grant is being taken this cycle
//   grant      : one-hot winner, grant_idx : its index, any_req : some req high
// Search starts at pointer+1; reset pointer is N-1 so source 0 wins first.
module rr_arbiter #(
  parameter  int unsigned N  = 3,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  input  logic          grant_en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] cand;

  // First requester found walking forward from the slot after the pointer.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = IW'((32'(ptr_q) + off) % N);
      if (!any_req && req[cand]) begin
        any_req     = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_en) ptr_d = last_grant;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ptr_q <= IW'(N - 1);
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ report sources. Grants round-robin,
// latches the winning payload and sends SYNC, ID, payload (MSB byte first), CHK
// one byte per data_rdy/tx_busy handshake.
//   clock, reset_n : system clock, async active-low reset
//   bus (master)   : req/payload/ack to sources, uart_data/uart_data_rdy/
//                    uart_tx_busy to the UART, busy while a packet is in flight
module uart_tx_scheduler
  import utils::*;
#(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned PAYLOAD_BYTES = 2
) (
  input logic                 clock,
  input logic                 reset_n,
  uart_tx_scheduler_if.master bus
);

  localparam int unsigned IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PW       = 8 * PAYLOAD_BYTES;
  localparam int unsigned BIW      = 3;
  localparam int unsigned LAST_IDX = PAYLOAD_BYTES + 2;

  uart_sched_state_t  state_q, state_d;
  logic [PW-1:0]      payload_q, payload_d;
  logic [7:0]         id_q, id_d;
  logic [7:0]         chk_q, chk_d;
  logic [BIW-1:0]     idx_q, idx_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [7:0]         data_q, data_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               any_req;
  logic               grant_en_c;
  logic               last_byte_c;

  assign grant_en_c  = (state_q == IDLE) && any_req;
  assign last_byte_c = (idx_q == BIW'(LAST_IDX));

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (bus.req),
    .last_grant (grant_idx),
    .grant_en   (grant_en_c),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_req    (any_req)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req)           state_d = ISSUE;
      ISSUE:   if (!bus.uart_tx_busy) state_d = WAIT_HI;
      WAIT_HI: if (bus.uart_tx_busy)  state_d = WAIT_LO;
      WAIT_LO: if (!bus.uart_tx_busy) state_d = last_byte_c ? IDLE : ISSUE;
      default:                        state_d = IDLE;
    endcase
  end

  // Output and datapath next values; pulses default low, data holds
  always_comb begin
    payload_d = payload_q;
    id_d      = id_q;
    chk_d     = chk_q;
    idx_d     = idx_q;
    data_d    = data_q;
    ack_d     = '0;
    rdy_d     = 1'b0;
    busy_d    = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (any_req) begin
          payload_d = bus.payload[grant_idx];
          id_d      = 8'(grant_idx);
          chk_d     = 8'h00;
          idx_d     = '0;
          ack_d     = grant;
        end
      end
      ISSUE: begin
        if (!bus.uart_tx_busy) begin
          rdy_d = 1'b1;
          if (idx_q == BIW'(0)) begin
            data_d = UART_SYNC_BYTE;
          end else if (idx_q == BIW'(1)) begin
            data_d = id_q;
            chk_d  = chk_q ^ id_q;
          end else if (last_byte_c) begin
            data_d = chk_q;
          end else begin
            // Payload goes out MSB byte first by shifting the latched copy left
            data_d    = payload_q[PW-1 -: 8];
            chk_d     = chk_q ^ payload_q[PW-1 -: 8];
            payload_d = payload_q << 8;
          end
        end
      end
      WAIT_LO: begin
        if (!bus.uart_tx_busy && !last_byte_c) idx_d = idx_q + BIW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      payload_q <= '0;
      id_q      <= 8'h00;
      chk_q     <= 8'h00;
      idx_q     <= '0;
      ack_q     <= '0;
      data_q    <= 8'h00;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      payload_q <= payload_d;
      id_q      <= id_d;
      chk_q     <= chk_d;
      idx_q     <= idx_d;
      ack_q     <= ack_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.ack           = ack_q;
  assign bus.uart_data     = data_q;
  assign bus.uart_data_rdy = rdy_q;
  assign bus.busy          = busy_q;

endmodule
